cv32e41p_apu_wb_tracker: RTL and testbench
==========================================

CV32E41P_APU_WB_TRACKER -- requirements
Module: cv32e41p_apu_wb_tracker

Interface
REQ-001 Parameter DEPTH, default 2, maximum outstanding APU requests; legal values 1..4.
REQ-002 Parameter WADDR_W, default 6, width of the register write address (bit 5 set = FP register f0..f31, clear = x0..x31).
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-high.
REQ-005 apu_req_i  input  1  core requests an APU operation.
REQ-006 apu_waddr_i  input  WADDR_W  destination register of the requested operation.
REQ-007 apu_req_o  output  1  request forwarded to the APU.
REQ-008 apu_gnt_i  input  1  APU accepts the forwarded request.
REQ-009 apu_rvalid_i  input  1  APU returns a result, in request order.
REQ-010 apu_rdata_i  input  32  APU result data.
REQ-011 apu_valid_o  output  1  registered writeback strobe.
REQ-012 apu_waddr_o  output  WADDR_W  writeback register address.
REQ-013 apu_result_o  output  32  writeback data.
REQ-014 busy_o  output  1  at least one request outstanding.
REQ-015 full_o  output  1  DEPTH requests outstanding.
REQ-016 err_o  output  1  sticky protocol error.
REQ-017 retired_cnt_o  output  32  count of results written back.

Function
REQ-018 Shall hold an in-order tag FIFO of WADDR_W-bit addresses with DEPTH entries, a read pointer, a write pointer and an occupancy counter of width clog2(DEPTH+1).
REQ-019 apu_req_o shall equal apu_req_i AND NOT full_o (combinational); a request is accepted when apu_req_o and apu_gnt_i are both high in a cycle.
REQ-020 On acceptance, apu_waddr_i shall be written at the write pointer; the pointer advances modulo DEPTH.
REQ-021 On apu_rvalid_i with occupancy > 0, the head entry shall be popped; in the next cycle apu_valid_o=1, apu_waddr_o=popped address, apu_result_o=apu_rdata_i of the pop cycle (latency exactly 1).
REQ-022 apu_valid_o shall be high for exactly one cycle per pop; apu_waddr_o and apu_result_o hold their last values while apu_valid_o is low.
REQ-023 Simultaneous acceptance and pop: occupancy unchanged; both pointers advance; with occupancy 0 a same-cycle pop is illegal (REQ-024) even if an acceptance occurs.
REQ-024 apu_rvalid_i with occupancy 0 shall set err_o, produce no writeback and leave pointers unchanged; err_o stays high until reset.
REQ-025 Since full_o blocks apu_req_o, no write shall occur at full; a pop at full clears full_o in the next cycle.
REQ-026 busy_o = (occupancy != 0); full_o = (occupancy == DEPTH); both registered-state derived, no combinational path from inputs.
REQ-027 retired_cnt_o shall increment by 1 in the cycle apu_valid_o is high, wrapping 0xFFFF_FFFF -> 0.

Reset
REQ-028 While rst_i is high: pointers, occupancy, apu_valid_o, apu_waddr_o, apu_result_o, err_o, retired_cnt_o all 0; busy_o=0, full_o=0.
REQ-029 Reset asserted mid-operation shall discard all outstanding tags; apu_rvalid_i arriving after reset release with occupancy 0 sets err_o.

Structure
REQ-030 DEPTH default, WADDR_W default and the FP-register address bit index shall live in the shared cv32e41p_apu_pkg package.
REQ-031 The tag FIFO shall be a sub-module named cv32e41p_apu_tag_fifo (push, pop, data in/out, occupancy, full, empty); the tracker owns handshake, writeback register, error and counter.

Verification
REQ-032 Single op: req+gnt with waddr=0x05, rvalid 3 cycles later with rdata=0xDEADBEEF -> next cycle apu_valid_o=1, apu_waddr_o=0x05, apu_result_o=0xDEADBEEF, retired_cnt_o=1, busy_o=0.
REQ-033 Fill: DEPTH=2, accept waddr 0x21 then 0x03 -> full_o=1, apu_req_o=0 while apu_req_i=1; rvalids return 0x11,0x22 -> writebacks (0x21,0x11) then (0x03,0x22) in order.
REQ-034 Simultaneous push/pop at occupancy 1 (head 0x0A, new 0x2B) -> occupancy stays 1, writeback 0x0A, next pop yields 0x2B.
REQ-035 Spurious rvalid with occupancy 0 -> err_o=1 sticky, apu_valid_o stays 0, retired_cnt_o unchanged.
REQ-036 rst_i asserted with 2 outstanding -> all outputs 0 asynchronously; after release, new req+gnt waddr=0x3F then rvalid -> writeback 0x3F, err_o=0.
REQ-037 Counter wrap: force retired_cnt_o to 0xFFFFFFFF via preceding ops or backdoor, one writeback -> retired_cnt_o=0.

Source files
------------

// File: rtl/cv32e41p_apu_pkg.sv
// Shared constants for the APU writeback tracker: default queue depth,
// register address width, and the bit that selects the FP register file.
package cv32e41p_apu_pkg;

    localparam int APU_DEPTH   = 2;
    localparam int APU_WADDR_W = 6;
    localparam int APU_FP_BIT  = 5;

    function automatic logic isFpReg(input logic [APU_WADDR_W-1:0] addr);
        return addr[APU_FP_BIT];
    endfunction

endpackage

// File: rtl/cv32e41p_apu_wb_tracker_if.sv
// Handshake bundle between the core, the tracker and the APU.
// The "slave" view belongs to the tracker; the "master" view belongs to the core/APU side.
interface cv32e41p_apu_wb_tracker_if #(
    parameter int WADDR_W = cv32e41p_apu_pkg::APU_WADDR_W
);
    logic               apu_req_i;
    logic [WADDR_W-1:0] apu_waddr_i;
    logic               apu_req_o;
    logic               apu_gnt_i;
    logic               apu_rvalid_i;
    logic [31:0]        apu_rdata_i;
    logic               apu_valid_o;
    logic [WADDR_W-1:0] apu_waddr_o;
    logic [31:0]        apu_result_o;

    modport slave (
        input  apu_req_i, apu_waddr_i, apu_gnt_i, apu_rvalid_i, apu_rdata_i,
        output apu_req_o, apu_valid_o, apu_waddr_o, apu_result_o
    );

    modport master (
        output apu_req_i, apu_waddr_i, apu_gnt_i, apu_rvalid_i, apu_rdata_i,
        input  apu_req_o, apu_valid_o, apu_waddr_o, apu_result_o
    );
endinterface

// File: rtl/cv32e41p_apu_tag_fifo.sv
// In-order queue of destination addresses for outstanding APU operations.
// Push at full and pop at empty are ignored, so the pointers can never corrupt.
module cv32e41p_apu_tag_fifo #(
    parameter int DEPTH = cv32e41p_apu_pkg::APU_DEPTH,
    parameter int WIDTH = cv32e41p_apu_pkg::APU_WADDR_W,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic [CNT_W-1:0] occupancy_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0] r_count;
    logic             w_doPush;
    logic             w_doPop;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return ptr + PTR_W'(1);
    endfunction

    assign full_o      = (r_count == CNT_W'(DEPTH));
    assign empty_o     = (r_count == '0);
    assign occupancy_o = r_count;
    assign data_o      = r_mem[r_rdPtr];
    assign w_doPush    = push_i && !full_o;
    assign w_doPop     = pop_i && !empty_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_doPush) begin
                r_mem[r_wrPtr] <= data_i;
                r_wrPtr        <= nextPtr(r_wrPtr);
            end
            if (w_doPop) begin
                r_rdPtr <= nextPtr(r_rdPtr);
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/cv32e41p_apu_wb_tracker.sv
// Tracks outstanding APU requests and turns in-order APU results into a
// registered register-file writeback, flagging results that arrive with nothing pending.
module cv32e41p_apu_wb_tracker
    import cv32e41p_apu_pkg::*;
#(
    parameter int DEPTH   = APU_DEPTH,
    parameter int WADDR_W = APU_WADDR_W
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    cv32e41p_apu_wb_tracker_if.slave    apu,
    output logic                        busy_o,
    output logic                        full_o,
    output logic                        err_o,
    output logic [31:0]                 retired_cnt_o
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    if (DEPTH < 1 || DEPTH > 4) begin : g_badDepth
        $error("cv32e41p_apu_wb_tracker: DEPTH must be in 1..4");
    end

    logic [WADDR_W-1:0] w_headAddr;
    logic [CNT_W-1:0]   w_occupancy;
    logic               w_full;
    logic               w_empty;
    logic               w_accept;
    logic               w_pop;
    logic               w_spurious;

    logic               r_valid;
    logic [WADDR_W-1:0] r_waddr;
    logic [31:0]        r_result;
    logic               r_err;
    logic [31:0]        r_retiredCnt;

    // Blocking the request at full guarantees the queue never overflows.
    assign apu.apu_req_o = apu.apu_req_i && !w_full;
    assign w_accept      = apu.apu_req_o && apu.apu_gnt_i;
    assign w_pop         = apu.apu_rvalid_i && !w_empty;
    assign w_spurious    = apu.apu_rvalid_i && w_empty;

    cv32e41p_apu_tag_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WADDR_W),
        .CNT_W (CNT_W)
    ) u_tagFifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (w_accept),
        .pop_i       (w_pop),
        .data_i      (apu.apu_waddr_i),
        .data_o      (w_headAddr),
        .occupancy_o (w_occupancy),
        .full_o      (w_full),
        .empty_o     (w_empty)
    );

    // Writeback data holds between strobes; the counter steps on the same edge as the strobe.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid      <= 1'b0;
            r_waddr      <= '0;
            r_result     <= '0;
            r_err        <= 1'b0;
            r_retiredCnt <= '0;
        end else begin
            r_valid <= w_pop;
            if (w_pop) begin
                r_waddr      <= w_headAddr;
                r_result     <= apu.apu_rdata_i;
                r_retiredCnt <= r_retiredCnt + 32'd1;
            end
            if (w_spurious) begin
                r_err <= 1'b1;
            end
        end
    end

    assign apu.apu_valid_o  = r_valid;
    assign apu.apu_waddr_o  = r_waddr;
    assign apu.apu_result_o = r_result;
    assign busy_o           = (w_occupancy != '0);
    assign full_o           = w_full;
    assign err_o            = r_err;
    assign retired_cnt_o    = r_retiredCnt;
endmodule

// File: tb/tb_cv32e41p_apu_wb_tracker.sv
// Directed bench for the APU writeback tracker (DEPTH=2): a vector table for
// the steady-state behaviour plus hand sequences for reset and counter wrap.
module tb_cv32e41p_apu_wb_tracker;

    typedef struct {
        logic        req;
        logic        gnt;
        logic [5:0]  waddr;
        logic        rvalid;
        logic [31:0] rdata;
        logic        expReqO;
        logic        expValid;
        logic [5:0]  expWaddr;
        logic [31:0] expResult;
        logic        expBusy;
        logic        expFull;
        logic        expErr;
        logic [31:0] expCnt;
    } vec_t;

    localparam int NUM_VECS = 18;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        busy;
    logic        full;
    logic        err;
    logic [31:0] retiredCnt;
    int          testsRun = 0;
    int          testsFailed = 0;
    vec_t        vecs [NUM_VECS];

    cv32e41p_apu_wb_tracker_if #(.WADDR_W(6)) bus ();

    cv32e41p_apu_wb_tracker #(
        .DEPTH   (2),
        .WADDR_W (6)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .apu           (bus),
        .busy_o        (busy),
        .full_o        (full),
        .err_o         (err),
        .retired_cnt_o (retiredCnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic driveInputs(input logic req, input logic gnt, input logic [5:0] waddr,
                               input logic rvalid, input logic [31:0] rdata);
        bus.apu_req_i    = req;
        bus.apu_gnt_i    = gnt;
        bus.apu_waddr_i  = waddr;
        bus.apu_rvalid_i = rvalid;
        bus.apu_rdata_i  = rdata;
    endtask

    // One clock of stimulus: inputs change at the falling edge, results sampled 1ns after the rising edge.
    task automatic driveCycle(input logic req, input logic gnt, input logic [5:0] waddr,
                              input logic rvalid, input logic [31:0] rdata);
        @(negedge clk);
        driveInputs(req, gnt, waddr, rvalid, rdata);
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        @(negedge clk);
        driveInputs(v.req, v.gnt, v.waddr, v.rvalid, v.rdata);
        #1;
        checkOutput($sformatf("v%0d.req_o", idx), {31'd0, bus.apu_req_o}, {31'd0, v.expReqO});
        @(posedge clk);
        #1;
        checkOutput($sformatf("v%0d.valid", idx),  {31'd0, bus.apu_valid_o}, {31'd0, v.expValid});
        checkOutput($sformatf("v%0d.waddr", idx),  {26'd0, bus.apu_waddr_o}, {26'd0, v.expWaddr});
        checkOutput($sformatf("v%0d.result", idx), bus.apu_result_o, v.expResult);
        checkOutput($sformatf("v%0d.busy", idx),   {31'd0, busy}, {31'd0, v.expBusy});
        checkOutput($sformatf("v%0d.full", idx),   {31'd0, full}, {31'd0, v.expFull});
        checkOutput($sformatf("v%0d.err", idx),    {31'd0, err},  {31'd0, v.expErr});
        checkOutput($sformatf("v%0d.cnt", idx),    retiredCnt, v.expCnt);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".valid"},  {31'd0, bus.apu_valid_o}, 32'd0);
        checkOutput({tag, ".waddr"},  {26'd0, bus.apu_waddr_o}, 32'd0);
        checkOutput({tag, ".result"}, bus.apu_result_o, 32'd0);
        checkOutput({tag, ".busy"},   {31'd0, busy}, 32'd0);
        checkOutput({tag, ".full"},   {31'd0, full}, 32'd0);
        checkOutput({tag, ".err"},    {31'd0, err},  32'd0);
        checkOutput({tag, ".cnt"},    retiredCnt, 32'd0);
    endtask

    initial begin
        //           req gnt waddr  rv  rdata          reqO vld  waddr  result         busy full err cnt
        vecs[0]  = '{0, 0, 6'h00, 0, 32'h0,        0, 0, 6'h00, 32'h0,        0, 0, 0, 32'd0};
        vecs[1]  = '{1, 1, 6'h05, 0, 32'h0,        1, 0, 6'h00, 32'h0,        1, 0, 0, 32'd0};
        vecs[2]  = '{0, 0, 6'h00, 0, 32'h0,        0, 0, 6'h00, 32'h0,        1, 0, 0, 32'd0};
        vecs[3]  = '{0, 0, 6'h00, 0, 32'h0,        0, 0, 6'h00, 32'h0,        1, 0, 0, 32'd0};
        vecs[4]  = '{0, 0, 6'h00, 1, 32'hDEADBEEF, 0, 1, 6'h05, 32'hDEADBEEF, 0, 0, 0, 32'd1};
        vecs[5]  = '{0, 0, 6'h00, 0, 32'h0,        0, 0, 6'h05, 32'hDEADBEEF, 0, 0, 0, 32'd1};
        vecs[6]  = '{1, 1, 6'h21, 0, 32'h0,        1, 0, 6'h05, 32'hDEADBEEF, 1, 0, 0, 32'd1};
        vecs[7]  = '{1, 1, 6'h03, 0, 32'h0,        1, 0, 6'h05, 32'hDEADBEEF, 1, 1, 0, 32'd1};
        vecs[8]  = '{1, 1, 6'h3F, 0, 32'h0,        0, 0, 6'h05, 32'hDEADBEEF, 1, 1, 0, 32'd1};
        vecs[9]  = '{0, 0, 6'h00, 1, 32'h11,       0, 1, 6'h21, 32'h11,       1, 0, 0, 32'd2};
        vecs[10] = '{0, 0, 6'h00, 1, 32'h22,       0, 1, 6'h03, 32'h22,       0, 0, 0, 32'd3};
        vecs[11] = '{1, 1, 6'h0A, 0, 32'h0,        1, 0, 6'h03, 32'h22,       1, 0, 0, 32'd3};
        vecs[12] = '{1, 1, 6'h2B, 1, 32'hAAAA0001, 1, 1, 6'h0A, 32'hAAAA0001, 1, 0, 0, 32'd4};
        vecs[13] = '{0, 0, 6'h00, 1, 32'hBBBB0002, 0, 1, 6'h2B, 32'hBBBB0002, 0, 0, 0, 32'd5};
        vecs[14] = '{0, 0, 6'h00, 1, 32'h12345678, 0, 0, 6'h2B, 32'hBBBB0002, 0, 0, 1, 32'd5};
        vecs[15] = '{0, 0, 6'h00, 0, 32'h0,        0, 0, 6'h2B, 32'hBBBB0002, 0, 0, 1, 32'd5};
        vecs[16] = '{1, 1, 6'h07, 1, 32'h0000CAFE, 1, 0, 6'h2B, 32'hBBBB0002, 1, 0, 1, 32'd5};
        vecs[17] = '{0, 0, 6'h00, 1, 32'h00000777, 0, 1, 6'h07, 32'h00000777, 0, 0, 1, 32'd6};

        driveInputs(0, 0, 6'h00, 0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("inReset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NUM_VECS; i++) begin
            applyStimulus(vecs[i], i);
        end

        // Asynchronous reset with two tags outstanding.
        driveCycle(1, 1, 6'h11, 0, 32'h0);
        driveCycle(1, 1, 6'h12, 0, 32'h0);
        @(negedge clk);
        driveInputs(0, 0, 6'h00, 0, 32'h0);
        #1;
        checkOutput("preRst.full", {31'd0, full}, 32'd1);
        rst = 1'b1;
        #1;
        checkAllZero("asyncRst");
        @(negedge clk);
        rst = 1'b0;
        driveCycle(1, 1, 6'h3F, 0, 32'h0);
        driveCycle(0, 0, 6'h00, 1, 32'h0BADF00D);
        checkOutput("postRst.valid",  {31'd0, bus.apu_valid_o}, 32'd1);
        checkOutput("postRst.waddr",  {26'd0, bus.apu_waddr_o}, 32'h3F);
        checkOutput("postRst.result", bus.apu_result_o, 32'h0BADF00D);
        checkOutput("postRst.err",    {31'd0, err}, 32'd0);
        checkOutput("postRst.cnt",    retiredCnt, 32'd1);
        checkOutput("postRst.busy",   {31'd0, busy}, 32'd0);

        // Outstanding tag discarded by reset: the late result is spurious.
        driveCycle(1, 1, 6'h15, 0, 32'h0);
        @(negedge clk);
        driveInputs(0, 0, 6'h00, 0, 32'h0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        driveCycle(0, 0, 6'h00, 1, 32'h00000005);
        checkOutput("lateRv.err",   {31'd0, err}, 32'd1);
        checkOutput("lateRv.valid", {31'd0, bus.apu_valid_o}, 32'd0);
        checkOutput("lateRv.cnt",   retiredCnt, 32'd0);

        // Retired counter wrap, preloaded through the hierarchy.
        driveCycle(1, 1, 6'h2C, 0, 32'h0);
        @(negedge clk);
        driveInputs(0, 0, 6'h00, 0, 32'h0);
        force dut.r_retiredCnt = 32'hFFFFFFFF;
        #1;
        release dut.r_retiredCnt;
        #1;
        checkOutput("wrap.preload", retiredCnt, 32'hFFFFFFFF);
        driveCycle(0, 0, 6'h00, 1, 32'h5A5A5A5A);
        checkOutput("wrap.cnt",    retiredCnt, 32'd0);
        checkOutput("wrap.valid",  {31'd0, bus.apu_valid_o}, 32'd1);
        checkOutput("wrap.waddr",  {26'd0, bus.apu_waddr_o}, 32'h2C);
        driveCycle(0, 0, 6'h00, 0, 32'h0);
        checkOutput("wrap.hold",   retiredCnt, 32'd0);
        checkOutput("wrap.strobe", {31'd0, bus.apu_valid_o}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
